// File: rtl/flip_flop.sv
// Parameterizable D register chain with clock enable, synchronous reset and a valid flag.
// Optional rise/fall edge-detect outputs are enabled with the FLIP_FLOP_EDGE_DETECT_EN macro.
module flip_flop #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
`ifdef FLIP_FLOP_EDGE_DETECT_EN
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`endif
    output logic             q_valid
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [STAGES-1:0]            vld_q, vld_d;

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage_d[i] = RESET_VALUE;
            vld_d = '0;
        end else if (en) begin
            stage_d[0] = d;
            vld_d[0]   = 1'b1;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
        vld_q   <= vld_d;
    end

    assign q       = stage_q[STAGES-1];
    assign q_valid = vld_q[STAGES-1];

`ifdef FLIP_FLOP_EDGE_DETECT_EN
    // Shadow holds q as of the previous enabled edge; edges are reported one enabled cycle after q moves.
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        shadow_d = shadow_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        if (rst) begin
            shadow_d = RESET_VALUE;
            rise_d   = '0;
            fall_d   = '0;
        end else if (en) begin
            shadow_d = q;
            rise_d   = q & ~shadow_q;
            fall_d   = ~q & shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: tb/tb_flip_flop.sv
// Bench for flip_flop: three configurations driven together, checked against a history-queue model.
module tb_flip_flop;

    logic       clk = 1'b0;
    logic       rst, en;
    logic       d_a;
    logic [7:0] d_b;
    logic [3:0] d_c;
    logic       q_a, v_a;
    logic [7:0] q_b;
    logic       v_b;
    logic [3:0] q_c;
    logic       v_c;

    int total = 0;
    int bad   = 0;

    logic       hist_a[$];
    logic [7:0] hist_b[$];
    logic [3:0] hist_c[$];

    always #5 clk = ~clk;

`ifdef FLIP_FLOP_EDGE_DETECT_EN
    logic       rise_a, fall_a;
    logic [7:0] rise_b, fall_b;
    logic [3:0] rise_c, fall_c;
`endif

    flip_flop dut_a (
        .clk(clk), .rst(rst), .en(en), .d(d_a), .q(q_a),
`ifdef FLIP_FLOP_EDGE_DETECT_EN
        .rise(rise_a), .fall(fall_a),
`endif
        .q_valid(v_a));

    flip_flop #(.WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .d(d_b), .q(q_b),
`ifdef FLIP_FLOP_EDGE_DETECT_EN
        .rise(rise_b), .fall(fall_b),
`endif
        .q_valid(v_b));

    flip_flop #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'hF)) dut_c (
        .clk(clk), .rst(rst), .en(en), .d(d_c), .q(q_c),
`ifdef FLIP_FLOP_EDGE_DETECT_EN
        .rise(rise_c), .fall(fall_c),
`endif
        .q_valid(v_c));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // q after j enabled edges since reset for the single-stage, single-bit instance
    function automatic logic qa_after(input int j);
        return (j >= 1) ? hist_a[j-1] : 1'b0;
    endfunction

    // Apply one cycle of inputs, let an edge pass, update the model and compare everything.
    task automatic tick(input logic r, input logic e, input logic [7:0] dv);
        int n;
        rst = r; en = e;
        d_a = dv[0]; d_b = dv; d_c = dv[3:0];
        @(posedge clk);
        #1;
        if (r) begin
            hist_a.delete(); hist_b.delete(); hist_c.delete();
        end else if (e) begin
            hist_a.push_back(dv[0]);
            hist_b.push_back(dv);
            hist_c.push_back(dv[3:0]);
        end
        chk("a_q", {7'b0, q_a}, {7'b0, (hist_a.size() >= 1) ? hist_a[hist_a.size()-1] : 1'b0});
        chk("a_valid", {7'b0, v_a}, {7'b0, hist_a.size() >= 1});
        chk("b_q", q_b, (hist_b.size() >= 1) ? hist_b[hist_b.size()-1] : 8'h00);
        chk("b_valid", {7'b0, v_b}, {7'b0, hist_b.size() >= 1});
        chk("c_q", {4'b0, q_c}, {4'b0, (hist_c.size() >= 3) ? hist_c[hist_c.size()-3] : 4'hF});
        chk("c_valid", {7'b0, v_c}, {7'b0, hist_c.size() >= 3});
`ifdef FLIP_FLOP_EDGE_DETECT_EN
        n = hist_a.size();
        chk("a_rise", {7'b0, rise_a}, {7'b0, (n >= 2) && qa_after(n-1) && !qa_after(n-2)});
        chk("a_fall", {7'b0, fall_a}, {7'b0, (n >= 2) && !qa_after(n-1) && qa_after(n-2)});
`else
        n = 0;
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; d_a = 1'b1; d_b = '0; d_c = '0;
        // reset with d=1, then release with d=0
        tick(1, 1, 8'h01);
        tick(1, 1, 8'h01);
        tick(0, 1, 8'h00);
        // capture / toggle, each value held two cycles
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, (i % 2 == 1) ? 8'h01 : 8'h00);
            tick(0, 1, (i % 2 == 1) ? 8'h01 : 8'h00);
        end
        // reset mid-operation while d=1
        tick(0, 1, 8'h01);
        tick(1, 1, 8'h01);
        tick(1, 1, 8'h01);
        tick(1, 0, 8'h01);
        // enable hold
        tick(0, 1, 8'hA5);
        for (int i = 0; i < 3; i++) tick(0, 0, 8'h3C);
        tick(0, 1, 8'h3C);
        // pipeline latency on the 3-stage instance
        tick(1, 1, 8'h00);
        for (int i = 1; i <= 6; i++) tick(0, 1, 8'(i));
        // edge pattern 0->1->0 with a hold in between
        tick(0, 1, 8'h00);
        tick(0, 1, 8'h01);
        tick(0, 1, 8'h01);
        tick(0, 0, 8'h00);
        tick(0, 1, 8'h00);
        tick(0, 1, 8'h00);
        // randomized traffic with occasional resets and enable gaps
        for (int i = 0; i < 300; i++)
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
